// File: rtl/puzzle_pkg.sv
// Shared types and constants for the puzzle move sequencer: FSM states,
// register-file indices, move directions and the default board width.
package puzzle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WR_ST,
      ST_WR_PL,
      ST_WR_CNT,
      ST_CMP,
      ST_DONE
   } state_t;

   localparam int PUZZLE_WIDTH = 28;

   localparam logic [3:0] REG_STATE = 4'd0;
   localparam logic [3:0] REG_GOAL  = 4'd1;
   localparam logic [3:0] REG_PLACE = 4'd2;
   localparam logic [3:0] REG_CNT   = 4'd7;
   localparam logic [3:0] REG_COMP  = 4'd9;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Bits needed to hold a cell index; never less than one.
   function automatic int pos_width(input int ncell);
      return (ncell > 1) ? $clog2(ncell) : 1;
   endfunction

endpackage

// File: rtl/puzzle_move_ctrl_nibble_swap.sv
// Combinational exchange of two 4-bit cells (i_p, i_n) inside a WIDTH-bit board word.
module nibble_swap
   import puzzle_pkg::*;
#(
   parameter int WIDTH = PUZZLE_WIDTH,
   parameter int PW    = pos_width(WIDTH / 4)
) (
   input  logic [WIDTH-1:0] i_word,
   input  logic [PW-1:0]    i_p,
   input  logic [PW-1:0]    i_n,
   output logic [WIDTH-1:0] o_word
);

   localparam int NCELL = WIDTH / 4;

   logic [3:0] w_cell_p;
   logic [3:0] w_cell_n;

   // Cells are picked with constant-index slices so out-of-range indices simply select nothing.
   always_comb begin
      w_cell_p = '0;
      w_cell_n = '0;
      for (int unsigned i = 0; i < NCELL; i++) begin
         if (PW'(i) == i_p) w_cell_p = i_word[4*i +: 4];
         if (PW'(i) == i_n) w_cell_n = i_word[4*i +: 4];
      end
      o_word = i_word;
      for (int unsigned i = 0; i < NCELL; i++) begin
         if (PW'(i) == i_p)      o_word[4*i +: 4] = w_cell_n;
         else if (PW'(i) == i_n) o_word[4*i +: 4] = w_cell_p;
      end
   end

endmodule

// File: rtl/puzzle_move_ctrl.sv
// Move sequencer owning the puzzle register-file write port; one tile move per command.
// Define PUZZLE_MOVE_CTRL_CMP_EN to add the goal-compare state (r9 write, solved flag).
module puzzle_move_ctrl
   import puzzle_pkg::*;
#(
   parameter int WIDTH = PUZZLE_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   input  logic             cmd_dir,
   output logic             cmd_ready,
   output logic [3:0]       src0,
   output logic [3:0]       src1,
   output logic [3:0]       dst,
   output logic             we,
   output logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             solved
);

   localparam int NCELL = WIDTH / 4;
   localparam int PW    = pos_width(NCELL);
   localparam logic [WIDTH-1:0] NCELL_W = WIDTH'(NCELL);
   localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(NCELL - 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_dir;
   logic             r_err;
   logic [WIDTH-1:0] r_s;
   logic [PW-1:0]    r_p;
   logic [PW-1:0]    r_n;
   logic [PW-1:0]    w_p;
   logic             w_illegal;
   logic [WIDTH-1:0] w_swapped;
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
   logic             r_solved;
`endif

   nibble_swap #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_swap (
      .i_word (r_s),
      .i_p    (r_p),
      .i_n    (r_n),
      .o_word (w_swapped)
   );

   // Legality is judged on the full-width position read so that any out-of-range value is rejected.
   assign w_p       = data1[PW-1:0];
   assign w_illegal = (data1 >= NCELL_W) ||
                      ((r_dir == DIR_LEFT)  && (data1 == '0)) ||
                      ((r_dir == DIR_RIGHT) && (data1 == LAST_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir <= DIR_LEFT;
         r_err <= 1'b0;
         r_s   <= '0;
         r_p   <= '0;
         r_n   <= '0;
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
         r_solved <= 1'b0;
`endif
      end else begin
         if ((r_state == ST_IDLE) && cmd_valid) begin
            r_dir <= cmd_dir;
            r_err <= 1'b0;
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
            r_solved <= 1'b0;
`endif
         end
         if (r_state == ST_LOAD) begin
            r_s   <= data0;
            r_p   <= w_p;
            r_n   <= (r_dir == DIR_RIGHT) ? w_p + PW'(1) : w_p - PW'(1);
            r_err <= w_illegal;
         end
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
         if (r_state == ST_CMP) r_solved <= (data0 == data1);
`endif
      end
   end

   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      solved    = 1'b0;
      we        = 1'b0;
      dst       = '0;
      data      = '0;
      src0      = '0;
      src1      = '0;
      case (r_state)
         ST_IDLE: begin
            busy      = 1'b0;
            cmd_ready = rst_n;
            if (cmd_valid) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            src0   = REG_STATE;
            src1   = REG_PLACE;
            w_next = w_illegal ? ST_DONE : ST_WR_ST;
         end
         ST_WR_ST: begin
            we     = 1'b1;
            dst    = REG_STATE;
            data   = w_swapped;
            w_next = ST_WR_PL;
         end
         ST_WR_PL: begin
            we     = 1'b1;
            dst    = REG_PLACE;
            data   = WIDTH'(r_n);
            w_next = ST_WR_CNT;
         end
         ST_WR_CNT: begin
            src0 = REG_CNT;
            we   = 1'b1;
            dst  = REG_CNT;
            data = data0 + WIDTH'(1);
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
            w_next = ST_CMP;
`else
            w_next = ST_DONE;
`endif
         end
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
         ST_CMP: begin
            src0    = REG_STATE;
            src1    = REG_GOAL;
            we      = 1'b1;
            dst     = REG_COMP;
            data[0] = (data0 == data1);
            w_next  = ST_DONE;
         end
`endif
         ST_DONE: begin
            done = 1'b1;
            err  = r_err;
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
            solved = r_solved;
`endif
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// Self-checking bench for puzzle_move_ctrl with a modelled register file and a cell-array move model.
module tb_puzzle_move_ctrl;

   localparam int W     = 28;
   localparam int NCELL = W / 4;
   localparam logic [W-1:0] MASK = '1;
`ifdef PUZZLE_MOVE_CTRL_CMP_EN
   localparam int  LAT    = 6;
   localparam bit  CMP_ON = 1'b1;
`else
   localparam int  LAT    = 5;
   localparam bit  CMP_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_dir = 1'b0;
   logic         cmd_ready;
   logic [3:0]   src0, src1, dst;
   logic         we;
   logic [W-1:0] data, data0, data1;
   logic         busy, done, err, solved;

   logic [W-1:0] rf [16];
   int           we_cnt = 0;
   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   assign data0 = rf[src0];
   assign data1 = rf[src1];

   always @(posedge clk) begin
      if (we) begin
         rf[dst] <= data;
         we_cnt  <= we_cnt + 1;
      end
   end

   puzzle_move_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_dir   (cmd_dir),
      .cmd_ready (cmd_ready),
      .src0      (src0),
      .src1      (src1),
      .dst       (dst),
      .we        (we),
      .data      (data),
      .data0     (data0),
      .data1     (data1),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .solved    (solved)
   );

   // Reference: board as an array of cells; exchange blank cell p with neighbour n.
   function automatic logic [W-1:0] swap_cells(input logic [W-1:0] s, input int p, input int n);
      logic [3:0]   cells [NCELL];
      logic [3:0]   t;
      logic [W-1:0] r;
      for (int i = 0; i < NCELL; i++) cells[i] = s[4*i +: 4];
      t = cells[p]; cells[p] = cells[n]; cells[n] = t;
      r = '0;
      for (int i = 0; i < NCELL; i++) r[4*i +: 4] = cells[i];
      return r;
   endfunction

   task automatic load_rf(input logic [W-1:0] st, goal, pos, cnt, comp);
      rf[0] = st; rf[1] = goal; rf[2] = pos; rf[7] = cnt; rf[9] = comp;
   endtask

   // Issues one command and waits (bounded) for done; returns latency counted in states.
   task automatic run_move(input logic dir, output int lat, output logic e, output logic s);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_dir = dir;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e = err; s = solved;
   endtask

   task automatic test_reset;
      #2;
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
      tests++; if (we !== 1'b0 || data !== '0 || dst !== '0) begin fails++; $display("FAIL reset_write got we=%b dst=%h data=%h want 0", we, dst, data); end
      tests++; if (src0 !== '0 || src1 !== '0 || err !== 1'b0 || solved !== 1'b0) begin fails++; $display("FAIL reset_misc got src0=%h src1=%h err=%b solved=%b want 0", src0, src1, err, solved); end
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL idle_ready got ready=%b busy=%b want 1/0", cmd_ready, busy); end
   endtask

   task automatic test_basic_right;
      int lat; logic e, s;
      load_rf(28'hADEB567, 28'h1234567, 28'd0, 28'd0, 28'h0000ABC);
      run_move(1'b1, lat, e, s);
      tests++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
      tests++; if (e !== 1'b0 || s !== 1'b0) begin fails++; $display("FAIL basic_flags got err=%b solved=%b want 0/0", e, s); end
      #10;
      tests++; if (rf[0] !== 28'hADEB576) begin fails++; $display("FAIL basic_r0 got %h want ADEB576", rf[0]); end
      tests++; if (rf[2] !== 28'd1 || rf[7] !== 28'd1) begin fails++; $display("FAIL basic_r2_r7 got %h/%h want 1/1", rf[2], rf[7]); end
      tests++; if (rf[9] !== (CMP_ON ? 28'd0 : 28'h0000ABC)) begin fails++; $display("FAIL basic_r9 got %h", rf[9]); end
   endtask

   task automatic test_illegal;
      int lat; logic e, s; int w0;
      logic [W-1:0] pos [4];
      logic         dirs [4];
      pos[0] = 28'd0; dirs[0] = 1'b0;
      pos[1] = 28'd6; dirs[1] = 1'b1;
      pos[2] = 28'd9; dirs[2] = 1'b0;
      pos[3] = 28'd9; dirs[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         load_rf(28'h1234567, 28'h1234567, pos[k], 28'h55, 28'h77);
         w0 = we_cnt;
         run_move(dirs[k], lat, e, s);
         tests++; if (lat !== 2) begin fails++; $display("FAIL illegal%0d_latency got %0d want 2", k, lat); end
         tests++; if (e !== 1'b1 || s !== 1'b0) begin fails++; $display("FAIL illegal%0d_flags got err=%b solved=%b want 1/0", k, e, s); end
         #10;
         tests++; if (we_cnt !== w0) begin fails++; $display("FAIL illegal%0d_we got %0d writes want 0", k, we_cnt - w0); end
         tests++; if (rf[0] !== 28'h1234567 || rf[2] !== pos[k] || rf[7] !== 28'h55 || rf[9] !== 28'h77) begin
            fails++; $display("FAIL illegal%0d_rf got r0=%h r2=%h r7=%h r9=%h", k, rf[0], rf[2], rf[7], rf[9]); end
      end
   endtask

   task automatic test_solve;
      int lat; logic e, s;
      load_rf(28'h5679DFA, 28'h5679DAF, 28'd1, 28'd3, 28'h0);
      run_move(1'b0, lat, e, s);
      tests++; if (e !== 1'b0 || s !== CMP_ON) begin fails++; $display("FAIL solve_flags got err=%b solved=%b want 0/%b", e, s, CMP_ON); end
      #10;
      tests++; if (rf[0] !== 28'h5679DAF || rf[2] !== 28'd0 || rf[7] !== 28'd4) begin fails++; $display("FAIL solve_rf got r0=%h r2=%h r7=%h want 5679DAF/0/4", rf[0], rf[2], rf[7]); end
      tests++; if (rf[9] !== (CMP_ON ? 28'd1 : 28'd0)) begin fails++; $display("FAIL solve_r9 got %h want %0d", rf[9], CMP_ON); end
   endtask

   task automatic test_wrap;
      int lat; logic e, s;
      load_rf(28'h0ABCDEF, 28'h0, 28'd3, 28'hFFFFFFF, 28'h0);
      run_move(1'b1, lat, e, s);
      #10;
      tests++; if (rf[7] !== 28'd0) begin fails++; $display("FAIL wrap_r7 got %h want 0", rf[7]); end
   endtask

   task automatic test_busy_ignore;
      int lat; logic idle_ok;
      load_rf(28'h7654321, 28'h0, 28'd3, 28'd10, 28'h0);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_dir = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_dir = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
      tests++; if (lat !== LAT || err !== 1'b0) begin fails++; $display("FAIL busy_move got lat=%0d err=%b want %0d/0", lat, err, LAT); end
      idle_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (busy !== 1'b0) idle_ok = 1'b0; end
      tests++; if (idle_ok !== 1'b1) begin fails++; $display("FAIL busy_requeue got busy after done want idle"); end
      tests++; if (rf[2] !== 28'd4 || rf[0] !== swap_cells(28'h7654321, 3, 4) || rf[7] !== 28'd11) begin
         fails++; $display("FAIL busy_rf got r0=%h r2=%h r7=%h", rf[0], rf[2], rf[7]); end
   endtask

   task automatic test_reset_mid;
      load_rf(28'h1234567, 28'h0, 28'd2, 28'd20, 28'h0);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_dir = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++; if (we !== 1'b1 || dst !== 4'd2) begin fails++; $display("FAIL midrst_state got we=%b dst=%h want 1/2", we, dst); end
      rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0 || we !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL midrst_async got busy=%b we=%b ready=%b want 000", busy, we, cmd_ready); end
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrst_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); end
      tests++; if (rf[0] !== swap_cells(28'h1234567, 2, 1) || rf[2] !== 28'd2 || rf[7] !== 28'd20) begin
         fails++; $display("FAIL midrst_partial got r0=%h r2=%h r7=%h", rf[0], rf[2], rf[7]); end
   endtask

   task automatic test_random;
      int lat; logic e, s;
      logic [W-1:0] st, goal, cnt, comp, pos, exp_st, exp_pos, exp_cnt, exp_comp;
      logic dir, legal, exp_sol;
      int p, n;
      for (int it = 0; it < 40; it++) begin
         st   = W'($urandom()) & MASK;
         cnt  = W'($urandom()) & MASK;
         comp = W'($urandom_range(0, 255));
         p    = int'($urandom_range(0, 9));
         pos  = W'(p);
         dir  = 1'($urandom_range(0, 1));
         n    = dir ? p + 1 : p - 1;
         legal = (p < NCELL) && (n >= 0) && (n < NCELL);
         exp_st = legal ? swap_cells(st, p, n) : st;
         goal = ($urandom_range(0, 1) == 1) ? exp_st : (W'($urandom()) & MASK);
         exp_pos  = legal ? W'(n) : pos;
         exp_cnt  = legal ? cnt + W'(1) : cnt;
         exp_sol  = legal && CMP_ON && (exp_st == goal);
         exp_comp = (legal && CMP_ON) ? W'(exp_sol) : comp;
         load_rf(st, goal, pos, cnt, comp);
         run_move(dir, lat, e, s);
         tests++; if (lat !== (legal ? LAT : 2) || e !== !legal) begin fails++; $display("FAIL rand%0d_timing got lat=%0d err=%b legal=%b", it, lat, e, legal); end
         tests++; if (s !== exp_sol) begin fails++; $display("FAIL rand%0d_solved got %b want %b", it, s, exp_sol); end
         #10;
         tests++; if (rf[0] !== exp_st || rf[2] !== exp_pos) begin fails++; $display("FAIL rand%0d_board got r0=%h r2=%h want %h/%h", it, rf[0], rf[2], exp_st, exp_pos); end
         tests++; if (rf[7] !== exp_cnt || rf[9] !== exp_comp) begin fails++; $display("FAIL rand%0d_cnt got r7=%h r9=%h want %h/%h", it, rf[7], rf[9], exp_cnt, exp_comp); end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = '0;
      test_reset;
      test_basic_right;
      test_illegal;
      test_solve;
      test_wrap;
      test_busy_ignore;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
